// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and a shift-add multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: start is ignored while busy; results hold until the next done.
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_lat_q, a_lat_d;
  logic [WIDTH-1:0]   b_lat_q, b_lat_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   y_hi_q, y_hi_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   res_y;
  logic               res_ovf;
  logic               res_err;
  logic [2*WIDTH-1:0] a_shift;
  logic               b_bit;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle ops, evaluated straight from the live inputs.
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    res_y   = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;
    case (op)
      OP_ADD: begin res_y = sum_w[WIDTH-1:0]; res_ovf = sum_w[WIDTH]; end
      OP_SUB: begin res_y = a - b;            res_ovf = (a < b);      end
      OP_NOR: begin res_y = ~(a | b);                                 end
      OP_SHL: begin res_y = {a[WIDTH-2:0], 1'b0}; res_ovf = a[WIDTH-1]; end
      OP_SHR: begin res_y = {1'b0, a[WIDTH-1:1]}; res_ovf = a[0];       end
      default: begin res_err = (op != OP_MUL); end
    endcase
  end

  // One shift-add step: add the latched multiplicand shifted by the bit index
  // whenever the corresponding multiplier bit is set.
  always_comb begin
    a_shift = {{WIDTH{1'b0}}, a_lat_q} << cnt_q;
    b_bit   = |(b_lat_q & (WIDTH'(1) << cnt_q));
    acc_nxt = acc_q + (b_bit ? a_shift : '0);
  end

  // Handshake FSM and result/flag update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    acc_d   = acc_q;
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            a_lat_d = a;
            b_lat_d = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            y_d    = res_y;
            y_hi_d = '0;
            ovf_d  = res_ovf;
            zero_d = (res_y == '0);
            err_d  = res_err;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_nxt[WIDTH-1:0];
          y_hi_d  = acc_nxt[2*WIDTH-1:WIDTH];
          ovf_d   = |acc_nxt[2*WIDTH-1:WIDTH];
          zero_d  = (acc_nxt[WIDTH-1:0] == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_lat_q <= '0;
      b_lat_q <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      y_hi_q  <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_lat_q <= a_lat_d;
      b_lat_q <= b_lat_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_MUL);
  assign done     = done_q;
  assign y        = y_q;
  assign y_hi     = y_hi_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases on a WIDTH=4 instance, random scoreboard on WIDTH=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] op4 = '0;
  logic       busy4, done4, ovf4, zero4, err4;
  logic [3:0] y4, yhi4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] op8 = '0;
  logic       busy8, done8, ovf8, zero8, err8;
  logic [7:0] y8, yhi8;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .op(op4),
    .busy(busy4), .done(done4), .y(y4), .y_hi(yhi4),
    .overflow(ovf4), .zero(zero4), .err(err4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .op(op8),
    .busy(busy8), .done(done8), .y(y8), .y_hi(yhi8),
    .overflow(ovf8), .zero(zero8), .err(err8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    start4 = 1'b1; op4 = o; a4 = x; b4 = z;
    step();
    start4 = 1'b0;
  endtask

  // Reference model for WIDTH=8, plain integer arithmetic.
  task automatic model8(input int o, input int x, input int z,
                        output int ey, output int ehi, output int eovf, output int eerr);
    int p;
    ey = 0; ehi = 0; eovf = 0; eerr = 0;
    case (o)
      0: begin p = x + z; ey = p % 256; eovf = (p > 255) ? 1 : 0; end
      1: begin ey = (x - z + 256) % 256; eovf = (x < z) ? 1 : 0; end
      2: begin p = x * z; ey = p % 256; ehi = p / 256; eovf = (ehi != 0) ? 1 : 0; end
      3: ey = 255 - (x | z);
      4: begin ey = (x * 2) % 256; eovf = (x >= 128) ? 1 : 0; end
      5: begin ey = x / 2; eovf = x % 2; end
      default: eerr = 1;
    endcase
  endtask

  initial begin
    int ey, ehi, eovf, eerr, lat, gap, x, z, o, prev_y, prev_hi, extra;

    // Reset state
    rst = 1'b1;
    step(); step();
    chk("rst_busy", busy4, 0); chk("rst_done", done4, 0); chk("rst_y", y4, 0);
    chk("rst_yhi", yhi4, 0); chk("rst_ovf", ovf4, 0); chk("rst_zero", zero4, 0);
    chk("rst_err", err4, 0);
    rst = 1'b0;
    step();
    chk("post_rst_done", done4, 0);

    // ADD 3+4
    go4(3'b000, 4'h3, 4'h4);
    chk("add_done", done4, 1); chk("add_y", y4, 7); chk("add_ovf", ovf4, 0);
    chk("add_zero", zero4, 0); chk("add_yhi", yhi4, 0); chk("add_busy", busy4, 0);
    step();
    chk("add_done_pulse", done4, 0);

    // ADD F+1 then SUB 0-1 back to back
    start4 = 1'b1; op4 = 3'b000; a4 = 4'hF; b4 = 4'h1;
    step();
    chk("addc_done", done4, 1); chk("addc_y", y4, 0); chk("addc_ovf", ovf4, 1);
    chk("addc_zero", zero4, 1);
    op4 = 3'b001; a4 = 4'h0; b4 = 4'h1;
    step();
    start4 = 1'b0;
    chk("sub_done", done4, 1); chk("sub_y", y4, 4'hF); chk("sub_ovf", ovf4, 1);
    chk("sub_zero", zero4, 0);
    step();

    // MUL F*F with an ignored start mid-operation
    go4(3'b010, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_busy%0d", i), busy4, 1);
      chk($sformatf("mul_nodone%0d", i), done4, 0);
      chk($sformatf("mul_hold%0d", i), y4, 4'hF);
      start4 = (i == 1); op4 = 3'b000; a4 = 4'h1; b4 = 4'h1;
      step();
    end
    start4 = 1'b0;
    chk("mul_done", done4, 1); chk("mul_busy_end", busy4, 0); chk("mul_y", y4, 1);
    chk("mul_yhi", yhi4, 4'hE); chk("mul_ovf", ovf4, 1); chk("mul_err", err4, 0);
    step();
    chk("mul_no_extra_done", done4, 0); chk("mul_y_hold", y4, 1);

    // Shifts, NOR and reserved opcode
    go4(3'b100, 4'h8, 4'h0);
    chk("shl_y", y4, 0); chk("shl_ovf", ovf4, 1); chk("shl_zero", zero4, 1);
    chk("shl_yhi", yhi4, 0);
    go4(3'b101, 4'h1, 4'hF);
    chk("shr_y", y4, 0); chk("shr_ovf", ovf4, 1);
    go4(3'b011, 4'h0, 4'h0);
    chk("nor0_y", y4, 4'hF); chk("nor0_ovf", ovf4, 0);
    go4(3'b011, 4'hA, 4'h5);
    chk("nor1_y", y4, 0); chk("nor1_zero", zero4, 1);
    go4(3'b110, 4'h3, 4'h3);
    chk("rsv_err", err4, 1); chk("rsv_y", y4, 0); chk("rsv_zero", zero4, 1);
    chk("rsv_done", done4, 1); chk("rsv_ovf", ovf4, 0);
    go4(3'b000, 4'h1, 4'h2);
    chk("err_clear", err4, 0);
    go4(3'b010, 4'h5, 4'h3);
    repeat (4) step();
    chk("mul2_y", y4, 4'hF); chk("mul2_yhi", yhi4, 0); chk("mul2_ovf", ovf4, 0);
    step();

    // Reset during the second MUL iteration
    go4(3'b010, 4'h3, 4'h3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy4, 0); chk("abort_done", done4, 0);
    chk("abort_y", y4, 0); chk("abort_yhi", yhi4, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) extra++;
      step();
    end
    chk("abort_no_done", extra, 0);
    go4(3'b000, 4'h1, 4'h1);
    chk("after_abort_y", y4, 2); chk("after_abort_done", done4, 1);
    step();

    // Random scoreboard on WIDTH=8
    prev_y = 0; prev_hi = 0;
    for (int n = 0; n < 200; n++) begin
      o = $urandom_range(0, 5);
      x = $urandom_range(0, 255);
      z = $urandom_range(0, 255);
      model8(o, x, z, ey, ehi, eovf, eerr);
      start8 = 1'b1; op8 = o[2:0]; a8 = x[7:0]; b8 = z[7:0];
      step();
      start8 = 1'b0;
      lat = 1;
      while (!done8 && lat < 20) begin
        if (lat == 1) chk("r_busy", busy8, 1);
        if (y8 !== prev_y[7:0] || yhi8 !== prev_hi[7:0]) chk("r_hold", {y8, yhi8}, {prev_y[7:0], prev_hi[7:0]});
        start8 = $urandom_range(0, 1); op8 = $urandom_range(0, 5);
        a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
        step();
        lat++;
      end
      start8 = 1'b0;
      chk($sformatf("r_lat op%0d", o), lat, (o == 2) ? 9 : 1);
      chk($sformatf("r_y op%0d a%0h b%0h", o, x, z), y8, ey);
      chk($sformatf("r_yhi op%0d a%0h b%0h", o, x, z), yhi8, ehi);
      chk($sformatf("r_ovf op%0d a%0h b%0h", o, x, z), ovf8, eovf);
      chk("r_zero", zero8, (ey == 0) ? 1 : 0);
      chk("r_err", err8, eerr);
      prev_y = ey; prev_hi = ehi;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("r_single_done", done8, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational 4-bit ALU.
- Operand width is set by WIDTH. A start/busy/done handshake is added, and a multi-cycle shift-add multiplier returns the full double-width product.
- Adds logical shift right and a reserved-opcode error flag.
- Sits between the lab's control FSM / operand registers and the display/flag logic. All outputs are registered.

Parameters:
- WIDTH, 4, operand and result word width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- op  input  3  opcode, latched on accepted start.
- busy  output  1  high while a multiply is iterating.
- done  output  1  one-cycle pulse: y/y_hi/flags are valid and updated.
- y  output  WIDTH  result low word.
- y_hi  output  WIDTH  product high word for MUL; 0 for all other ops.
- overflow  output  1  carry/borrow/shifted-out/product-overflow flag.
- zero  output  1  y == 0.
- err  output  1  reserved opcode was executed.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE. busy=0, done=0, y=0, y_hi=0, overflow=0, zero=0, err=0.
  - Counter, accumulator and operand latches are cleared.
  - Reset overrides start and any operation in progress.
- Opcodes:
  - 000 ADD: y=a+b mod 2^W; overflow = carry out (unsigned).
  - 001 SUB: y=a-b mod 2^W; overflow = borrow (a<b).
  - 010 MUL: {y_hi,y} = a*b (2W bits); overflow = (y_hi != 0).
  - 011 NOR: y=~(a|b); overflow=0.
  - 100 SHL1: y={a[W-2:0],0}; overflow=a[W-1]; b is ignored.
  - 101 SHR1: y={0,a[W-1:1]}; overflow=a[0]; b is ignored.
  - 110/111 reserved: y=0, y_hi=0, overflow=0, err=1.
- Flags:
  - zero is computed from the final y in the same cycle as done.
  - err=0 for every defined opcode.
  - Results and flags hold their values until the next done or reset.
- FSM states: IDLE, MUL.
- IDLE:
  - busy=0.
  - start=1 with op != 010: compute and register results and flags, and drive done=1 on the next cycle. State stays IDLE.
  - Latency for non-MUL ops is 1 cycle (start sampled at edge N, done high during cycle N+1).
  - Back-to-back starts on consecutive cycles are accepted. Each produces its own done pulse.
  - start=1 with op=010: latch a and b, clear the 2W-bit accumulator, set counter=0, and go to MUL. No done pulse.
- MUL:
  - busy=1.
  - Each cycle: if b_reg[cnt]=1, then acc += a_reg << cnt. Then cnt++.
  - After WIDTH iterations, write {y_hi,y}=acc, overflow, zero and err=0, pulse done, and return to IDLE.
  - Latency: start edge N → done during cycle N+WIDTH+1. busy is high during cycles N+1..N+WIDTH.
  - start is ignored while busy=1. Operand/op inputs may change freely; the latched copies are used.
  - Outputs keep their previous values during MUL until the final write.
- done:
  - Never high for more than one consecutive cycle for a MUL.
  - Never high in the cycle after reset.
- Reset mid-MUL: the operation is aborted, no done is issued, and all outputs return to reset values.

Test Plan:
- WIDTH=4, ADD a=3 b=4 → next cycle done=1, y=7, overflow=0, zero=0, y_hi=0, busy stays 0.
- WIDTH=4, ADD a=F b=1 → y=0, overflow=1, zero=1. Then SUB a=0 b=1 on the following cycle → y=F, overflow=1, zero=0, with two consecutive done pulses.
- WIDTH=4, MUL a=F b=F → busy=1 for exactly 4 cycles; done 5 cycles after start with y=1, y_hi=E, overflow=1. A start with op=000 pulsed mid-MUL is ignored, with no extra done.
- WIDTH=4, check the following cases:
  - SHL1 a=8 → y=0, overflow=1, zero=1.
  - SHR1 a=1 → y=0, overflow=1.
  - NOR a=0 b=0 → y=F, overflow=0.
  - NOR a=A b=5 → y=0, zero=1.
  - op=110 → err=1, y=0, zero=1, done pulses.
- WIDTH=4, assert rst on the 2nd MUL iteration of a=3 b=3 → next cycle busy=0, done=0, y=0, y_hi=0. No done follows. A subsequent ADD 1+1 gives y=2.
- WIDTH=8, 200 random {a,b,op∈0..5} with random start spacing → a scoreboard checks y/y_hi/overflow/zero/err against a behavioural model. MUL done latency is exactly 9 cycles and there is exactly one done per accepted start.
